alu_issuer: RTL and testbench
=============================

# alu_issuer

Sequential initiator for the 4-bit switch-driven ALU datapath: accepts an operation request (op, a, b) over a valid/ready handshake and packs it into the 11-bit switch command word. It waits a programmable settle time, then samples the 16-bit LED status word and decodes it into a result and flags. The response is presented on a second valid/ready handshake. It sits between a controller (test sequencer or CPU-side glue) and the ALU, driving the ALU's `sw` input and consuming its `ledr` output.

## Interface
- SETTLE_CYCLES, 2: cycles the target command word is held before `ledr` is sampled; legal range 1..15.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  issuer idle, can accept a request.
- req_op  in  3  ALU op: 000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 less-than, 111 equal.
- req_a  in  4  operand a.
- req_b  in  4  operand b.
- sw  out  11  command word to ALU, packed as {op[2:0], b[3:0], a[3:0]}.
- ledr  in  16  status word from ALU: [15:11] reserved (must be 0), [10:7] f, [6] zero, [5] overflow, [4] cout, [3:0] sum.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_op  out  3  op of this response.
- rsp_result  out  4  decoded result.
- rsp_cout  out  1  carry (add/sub only).
- rsp_overflow  out  1  signed overflow (add/sub only).
- rsp_zero  out  1  rsp_result == 0.
- rsp_err  out  1  ledr[15:11] nonzero at sample time.
- busy  out  1  state != IDLE.
- done_cnt  out  8  completed transactions, wraps 255 -> 0.

## Operation
- States: IDLE, PRIME, SETTLE, RESP. `req_ready` = (state == IDLE).
- IDLE: on `req_valid && req_ready`, latch op/a/b and go to PRIME. `sw` holds its previous value.
- PRIME, 1 cycle: `sw = {op ^ 3'b001, b, a}`. The ALU datapath re-evaluates only on an op-code change, so every transaction forces an op toggle. Go to SETTLE and load the counter with SETTLE_CYCLES-1.
- SETTLE: `sw = {op, b, a}`. Decrement the counter each cycle.
  - On the edge where the counter is 0, sample `ledr`, decode, and register all rsp_* fields.
  - Then go to RESP and increment `done_cnt`.
- Decode rules:
  - op 000/001: result = ledr[3:0]; cout = ledr[4]; overflow = ledr[5].
  - op 010..101: result = ledr[10:7]; cout = 0; overflow = 0.
  - op 110/111: result = {3'b000, ledr[7]}; cout = 0; overflow = 0.
  - All ops: rsp_zero = (result == 0); rsp_err = |ledr[15:11].
- RESP: `rsp_valid` = 1 and all rsp_* fields are held stable. On an edge with `rsp_ready` = 1, go to IDLE; `rsp_valid` falls at that edge.
- `req_valid` outside IDLE is ignored; there is no request queueing.
- Reset (any state, including mid-SETTLE or mid-RESP):
  - state = IDLE, sw = 0, counter = 0, done_cnt = 0.
  - All rsp_* outputs = 0 and rsp_valid = 0.
  - req_ready = 1 and busy = 0 immediately after reset.
  - An in-flight transaction is dropped with no response.

## Timing
- Accept edge E0 (req handshake). PRIME occupies cycle E0..E1. SETTLE occupies E1..E(1+SETTLE_CYCLES).
- `rsp_valid` rises at edge E(1+SETTLE_CYCLES): 3 edges after accept for the default. `ledr` is sampled at that same edge.
- If `rsp_ready` is already high, the response is consumed at the next edge. `req_ready` is high in the following cycle.
- Minimum request-to-request spacing: SETTLE_CYCLES + 3 cycles.
- `sw` changes only at the entry edges of PRIME and SETTLE. `ledr` must be stable from SETTLE entry until the sample edge.
- `done_cnt` increments at the edge `rsp_valid` rises.

## Test plan
- Reset: assert `rst` asynchronously mid-SETTLE -> sw=0, rsp_valid=0, req_ready=1 and done_cnt=0 before the next clk edge; no response appears afterwards.
- Add: op=000, a=7, b=1, ledr=16'h0028 -> sw shows {001,0001,0111} for 1 cycle, then {000,0001,0111}. rsp_valid rises 3 edges after accept with result=8, overflow=1, cout=0, zero=0, err=0.
- Equal: op=111, a=5, b=5, ledr=16'h0080 -> result=4'b0001, cout=0, overflow=0, zero=0. op=011, a=4'hC, b=4'h3, ledr=0 -> result=0, zero=1.
- Backpressure: hold rsp_ready=0 for 5 cycles while pulsing req_valid -> rsp_* stable, req_ready=0, sw unchanged, no second accept. rsp_ready=1 -> one response consumed, req_ready=1 next cycle.
- Error: ledr=16'h0800 on an op=000 transaction -> rsp_err=1, result=0, zero=1.
- SETTLE_CYCLES=1 build: latency 2 edges. 256 back-to-back transactions with rsp_ready tied high -> done_cnt wraps to 0 and spacing is 4 cycles.

Source files
------------

// File: rtl/alu_issuer.sv
// alu_issuer: sequential initiator for the switch-driven 4-bit ALU.
// Takes one (op, a, b) request, drives the packed switch word and waits a fixed settle
// time. It then samples the LED status word and returns a decoded response.
module alu_issuer #(
    // Cycles the target command word is held before ledr is sampled (legal 1..15).
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [3:0]  req_a,
    input  logic [3:0]  req_b,
    output logic [10:0] sw,
    input  logic [15:0] ledr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [2:0]  rsp_op,
    output logic [3:0]  rsp_result,
    output logic        rsp_cout,
    output logic        rsp_overflow,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic        busy,
    output logic [7:0]  done_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StSettle,
        StResp
    } state_e;

    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

    state_e      r_state;
    state_e      w_state_d;

    logic [2:0]  r_op;
    logic [3:0]  r_a;
    logic [3:0]  r_b;
    logic [10:0] r_sw;
    logic [3:0]  r_cnt;

    logic [2:0]  r_rsp_op;
    logic [3:0]  r_rsp_result;
    logic        r_rsp_cout;
    logic        r_rsp_overflow;
    logic        r_rsp_zero;
    logic        r_rsp_err;
    logic [7:0]  r_done_cnt;

    logic        w_accept;
    logic        w_sample;
    logic [3:0]  w_result;
    logic        w_cout;
    logic        w_overflow;
    logic        w_err;
    // The ALU's own zero flag is not used; rsp_zero is recomputed from the decoded result.
    logic        w_unused_ledr_zero;

    assign w_accept           = (r_state == StIdle) && req_valid;
    assign w_sample           = (r_state == StSettle) && (r_cnt == 4'd0);
    assign w_err              = |ledr[15:11];
    assign w_unused_ledr_zero = ledr[6];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:   if (req_valid) w_state_d = StPrime;
            StPrime:  w_state_d = StSettle;
            StSettle: if (r_cnt == 4'd0) w_state_d = StResp;
            StResp:   if (rsp_ready) w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // Decode the sampled status word according to the op in flight.
    always_comb begin
        w_result   = ledr[10:7];
        w_cout     = 1'b0;
        w_overflow = 1'b0;
        case (r_op)
            3'b000, 3'b001: begin
                w_result   = ledr[3:0];
                w_cout     = ledr[4];
                w_overflow = ledr[5];
            end
            3'b110, 3'b111: w_result = {3'b000, ledr[7]};
            default: ;
        endcase
    end

    // Request latch, switch word and settle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op  <= 3'd0;
            r_a   <= 4'd0;
            r_b   <= 4'd0;
            r_sw  <= 11'd0;
            r_cnt <= 4'd0;
        end else begin
            if (w_accept) begin
                r_op <= req_op;
                r_a  <= req_a;
                r_b  <= req_b;
                // The ALU only re-evaluates on an op change, so prime with a toggled op.
                r_sw <= {req_op ^ 3'b001, req_b, req_a};
            end
            if (r_state == StPrime) begin
                r_sw  <= {r_op, r_b, r_a};
                r_cnt <= SettleLoad;
            end else if (r_state == StSettle && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Response registers and completion counter, loaded on the sample edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_op       <= 3'd0;
            r_rsp_result   <= 4'd0;
            r_rsp_cout     <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_zero     <= 1'b0;
            r_rsp_err      <= 1'b0;
            r_done_cnt     <= 8'd0;
        end else if (w_sample) begin
            r_rsp_op       <= r_op;
            r_rsp_result   <= w_result;
            r_rsp_cout     <= w_cout;
            r_rsp_overflow <= w_overflow;
            r_rsp_zero     <= (w_result == 4'd0);
            r_rsp_err      <= w_err;
            r_done_cnt     <= r_done_cnt + 8'd1;
        end
    end

    assign req_ready    = (r_state == StIdle);
    assign busy         = (r_state != StIdle);
    assign rsp_valid    = (r_state == StResp);
    assign sw           = r_sw;
    assign rsp_op       = r_rsp_op;
    assign rsp_result   = r_rsp_result;
    assign rsp_cout     = r_rsp_cout;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_zero     = r_rsp_zero;
    assign rsp_err      = r_rsp_err;
    assign done_cnt     = r_done_cnt;

endmodule

// File: tb/tb_alu_issuer.sv
// Scoreboard bench for alu_issuer: a default build (settle 2) driven with directed vectors,
// and a settle-1 build run back-to-back for 256 transactions.
module tb_alu_issuer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default build.
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [3:0]  req_a = 4'd0;
    logic [3:0]  req_b = 4'd0;
    logic [10:0] sw;
    logic [15:0] ledr = 16'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [2:0]  rsp_op;
    logic [3:0]  rsp_result;
    logic        rsp_cout, rsp_overflow, rsp_zero, rsp_err, busy;
    logic [7:0]  done_cnt;

    // Settle-1 build.
    logic        req_valid1 = 1'b0;
    logic        req_ready1;
    logic [2:0]  req_op1 = 3'd0;
    logic [3:0]  req_a1 = 4'd0;
    logic [3:0]  req_b1 = 4'd0;
    logic [10:0] sw1;
    logic [15:0] ledr1 = 16'd0;
    logic        rsp_valid1;
    logic        rsp_ready1 = 1'b1;
    logic [2:0]  rsp_op1;
    logic [3:0]  rsp_result1;
    logic        rsp_cout1, rsp_overflow1, rsp_zero1, rsp_err1, busy1;
    logic [7:0]  done_cnt1;

    alu_issuer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .sw(sw), .ledr(ledr), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_op(rsp_op), .rsp_result(rsp_result), .rsp_cout(rsp_cout),
        .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy),
        .done_cnt(done_cnt)
    );

    alu_issuer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_op(req_op1), .req_a(req_a1), .req_b(req_b1), .sw(sw1), .ledr(ledr1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_op(rsp_op1),
        .rsp_result(rsp_result1), .rsp_cout(rsp_cout1), .rsp_overflow(rsp_overflow1),
        .rsp_zero(rsp_zero1), .rsp_err(rsp_err1), .busy(busy1), .done_cnt(done_cnt1)
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_done = 0;
    // Expected responses: {op, result, cout, overflow, zero, err}.
    logic [10:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever the default build hands over a response.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                logic [10:0] e;
                e = sb_q.pop_front();
                chk("rsp", 32'({rsp_op, rsp_result, rsp_cout, rsp_overflow, rsp_zero, rsp_err}),
                    32'(e));
            end
        end
    end

    // One full transaction on the default build; hold=1 applies 5 cycles of backpressure.
    task automatic run_txn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [15:0] led, input logic [7:0] exp, input bit hold);
        int k;
        k = 0;
        while (!req_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        ledr      = led;
        rsp_ready = !hold;
        @(posedge clk); #1;
        req_valid = 1'b0;
        sb_q.push_back({op, exp});
        chk("sw_prime", 32'(sw), 32'({op ^ 3'b001, b, a}));
        chk("busy_after_accept", 32'({req_ready, busy}), 32'({1'b0, 1'b1}));
        @(posedge clk); #1;
        chk("sw_settle", 32'(sw), 32'({op, b, a}));
        k = 1;
        while (!rsp_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("latency", 32'(k), 32'd3);
        exp_done = (exp_done + 1) % 256;
        chk("done_cnt", 32'(done_cnt), 32'(exp_done));
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                req_valid = (i % 2 == 0);
                req_op    = ~op;
                req_a     = 4'hF;
                req_b     = 4'h0;
                @(posedge clk); #1;
                chk("hold_hs", 32'({rsp_valid, req_ready}), 32'({1'b1, 1'b0}));
                chk("hold_rsp", 32'({rsp_op, rsp_result, rsp_cout, rsp_overflow, rsp_zero,
                    rsp_err}), 32'({op, exp}));
                chk("hold_sw", 32'(sw), 32'({op, b, a}));
            end
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("consumed", 32'({rsp_valid, req_ready, busy}), 32'({1'b0, 1'b1, 1'b0}));
        chk("done_stable", 32'(done_cnt), 32'(exp_done));
    endtask

    initial begin
        int cyc;
        int last_ready;
        int n_rsp;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'({sw, rsp_valid, req_ready, busy, done_cnt}),
            32'({11'd0, 1'b0, 1'b1, 1'b0, 8'd0}));
        chk("reset_rsp", 32'({rsp_op, rsp_result, rsp_cout, rsp_overflow, rsp_zero, rsp_err}),
            32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors: exp = {result, cout, overflow, zero, err}.
        run_txn(3'b000, 4'h7, 4'h1, 16'h0028, {4'h8, 4'b0100}, 1'b0); // add, overflow
        run_txn(3'b111, 4'h5, 4'h5, 16'h0080, {4'h1, 4'b0000}, 1'b0); // equal
        run_txn(3'b011, 4'hC, 4'h3, 16'h0000, {4'h0, 4'b0010}, 1'b0); // and, zero
        run_txn(3'b000, 4'h0, 4'h0, 16'h0800, {4'h0, 4'b0011}, 1'b0); // reserved bit set
        run_txn(3'b001, 4'h3, 4'h5, 16'h001E, {4'hE, 4'b1000}, 1'b0); // sub, carry
        run_txn(3'b101, 4'h6, 4'hC, 16'h053F, {4'hA, 4'b0000}, 1'b0); // xor, low bits ignored
        run_txn(3'b110, 4'h9, 4'h2, 16'h0700, {4'h0, 4'b0010}, 1'b0); // lt uses only bit 7
        run_txn(3'b010, 4'h0, 4'h0, 16'h0780, {4'hF, 4'b0000}, 1'b0); // not
        run_txn(3'b100, 4'h5, 4'h2, 16'h0380, {4'h7, 4'b0000}, 1'b1); // or, backpressure

        // Asynchronous reset in the middle of SETTLE drops the transaction.
        req_valid = 1'b1;
        req_op    = 3'b100;
        req_a     = 4'h1;
        req_b     = 4'h2;
        ledr      = 16'h0080;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", 32'({sw, rsp_valid, req_ready, busy, done_cnt}),
            32'({11'd0, 1'b0, 1'b1, 1'b0, 8'd0}));
        chk("rst_async_rsp", 32'({rsp_op, rsp_result, rsp_cout, rsp_overflow, rsp_zero,
            rsp_err}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_done = 0;
        repeat (8) @(posedge clk);
        #1;
        chk("no_rsp_after_rst", 32'({rsp_valid, busy, done_cnt}), 32'd0);

        // Post-reset transaction still works.
        run_txn(3'b000, 4'h2, 4'h3, 16'h0005, {4'h5, 4'b0000}, 1'b0);

        // Settle-1 build: 256 back-to-back transactions with rsp_ready tied high.
        chk("dut1_ready", 32'(req_ready1), 32'd1);
        req_op1    = 3'b000;
        req_a1     = 4'h2;
        req_b1     = 4'h3;
        ledr1      = 16'h0005;
        rsp_ready1 = 1'b1;
        req_valid1 = 1'b1;
        cyc        = 0;
        last_ready = 0;
        n_rsp      = 0;
        while (n_rsp < 256 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (rsp_valid1) begin
                n_rsp++;
                chk("lat1", 32'(cyc - last_ready), 32'd3);
                chk("rsp1", 32'({rsp_op1, rsp_result1, rsp_cout1, rsp_overflow1, rsp_zero1,
                    rsp_err1}), 32'({3'b000, 4'h5, 4'b0000}));
                chk("done_cnt1", 32'(done_cnt1), 32'(n_rsp % 256));
                if (n_rsp == 256) req_valid1 = 1'b0;
            end
            if (req_ready1) begin
                chk("spacing1", 32'(cyc - last_ready), 32'd4);
                last_ready = cyc;
            end
        end
        chk("rsp1_count", 32'(n_rsp), 32'd256);
        @(posedge clk); #1;
        chk("dut1_idle_wrap", 32'({req_ready1, busy1, rsp_valid1, done_cnt1}),
            32'({1'b1, 1'b0, 1'b0, 8'd0}));

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
